video_pattern_gen: RTL and testbench



---
 rtl/video_pattern_gen.sv | 161 ++++++++++++++++
 tb/tb_video_pattern_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_pattern_gen.sv
// Multi-mode HDMI test-pattern generator: colour bars, animated grid, grey ramp, solid cycle.
// Two-stage registered pipeline; mode and animation step only change at frame end.
module video_pattern_gen #(
    parameter int WIDTH           = 640,
    parameter int HEIGHT          = 480,
    parameter int COLS            = 8,
    parameter int ROWS            = 8,
    parameter int FRAMES_PER_STEP = 60,
    parameter int COLOR_W         = 8
) (
    input  logic                       pixel_clk,
    input  logic                       rst,
    input  logic                       active_video,
    input  logic [$clog2(WIDTH)-1:0]   h_pos,
    input  logic [$clog2(HEIGHT)-1:0]  v_pos,
    input  logic [1:0]                 mode,
    output logic [COLOR_W-1:0]         red,
    output logic [COLOR_W-1:0]         green,
    output logic [COLOR_W-1:0]         blue,
    output logic                       de_out,
    output logic [2:0]                 step
);

    localparam int HW = $clog2(WIDTH);
    localparam int VW = $clog2(HEIGHT);
    localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    // Palette entry as on/off flags {R,G,B}
    function automatic logic [2:0] pal(input logic [2:0] i);
        logic [2:0] c;
        case (i)
            3'd0:    c = 3'b111;
            3'd1:    c = 3'b110;
            3'd2:    c = 3'b011;
            3'd3:    c = 3'b010;
            3'd4:    c = 3'b101;
            3'd5:    c = 3'b100;
            3'd6:    c = 3'b001;
            default: c = 3'b000;
        endcase
        return c;
    endfunction

    // Frame-level state
    logic [1:0]         mode_q, mode_d;
    logic [2:0]         step_q, step_d;
    logic [FW-1:0]      frame_cnt_q, frame_cnt_d;

    // Stage 1
    logic [2:0]         h_idx_q, h_idx_d;
    logic [2:0]         v_idx_q, v_idx_d;
    logic [COLOR_W-1:0] ramp_q, ramp_d;
    logic               blank_q, blank_d;
    logic               de_q, de_d;
    logic [1:0]         pmode_q, pmode_d;
    logic [2:0]         pstep_q, pstep_d;

    // Stage 2
    logic [COLOR_W-1:0] red_q, red_d;
    logic [COLOR_W-1:0] green_q, green_d;
    logic [COLOR_W-1:0] blue_q, blue_d;
    logic               de_out_q, de_out_d;

    logic               fe;
    logic [63:0]        h_prod, v_prod, ramp_prod;
    logic [2:0]         cidx;
    logic [2:0]         flags;

    always_comb begin
        fe = active_video && (h_pos == HW'(WIDTH - 1)) && (v_pos == VW'(HEIGHT - 1));

        mode_d      = mode_q;
        step_d      = step_q;
        frame_cnt_d = frame_cnt_q;
        if (fe) begin
            mode_d = mode;
            if (frame_cnt_q == FW'(FRAMES_PER_STEP - 1)) begin
                frame_cnt_d = '0;
                step_d      = step_q + 3'd1;
            end else begin
                frame_cnt_d = frame_cnt_q + FW'(1);
            end
        end

        // Only idx mod 8 is ever used, so the indices are kept 3 bits wide
        h_prod    = 64'(h_pos) * 64'(COLS);
        v_prod    = 64'(v_pos) * 64'(ROWS);
        ramp_prod = 64'(h_pos) * ((64'd1 << COLOR_W) - 64'd1);
        h_idx_d   = 3'(h_prod / 64'(WIDTH));
        v_idx_d   = 3'(v_prod / 64'(HEIGHT));
        ramp_d    = COLOR_W'(ramp_prod / 64'(WIDTH - 1));
        blank_d   = !active_video || (32'(h_pos) >= 32'(WIDTH)) || (32'(v_pos) >= 32'(HEIGHT));
        de_d      = active_video;
        pmode_d   = mode_q;
        pstep_d   = step_q;

        cidx = h_idx_q;
        case (pmode_q)
            2'd1:    cidx = h_idx_q + v_idx_q + pstep_q;
            2'd3:    cidx = pstep_q;
            default: cidx = h_idx_q;
        endcase
        flags = pal(cidx);

        red_d    = {COLOR_W{flags[2]}};
        green_d  = {COLOR_W{flags[1]}};
        blue_d   = {COLOR_W{flags[0]}};
        if (pmode_q == 2'd2) begin
            red_d   = ramp_q;
            green_d = ramp_q;
            blue_d  = ramp_q;
        end
        if (blank_q) begin
            red_d   = '0;
            green_d = '0;
            blue_d  = '0;
        end
        de_out_d = de_q;
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            mode_q      <= '0;
            step_q      <= '0;
            frame_cnt_q <= '0;
            h_idx_q     <= '0;
            v_idx_q     <= '0;
            ramp_q      <= '0;
            blank_q     <= 1'b1;
            de_q        <= 1'b0;
            pmode_q     <= '0;
            pstep_q     <= '0;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
            de_out_q    <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            step_q      <= step_d;
            frame_cnt_q <= frame_cnt_d;
            h_idx_q     <= h_idx_d;
            v_idx_q     <= v_idx_d;
            ramp_q      <= ramp_d;
            blank_q     <= blank_d;
            de_q        <= de_d;
            pmode_q     <= pmode_d;
            pstep_q     <= pstep_d;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
            de_out_q    <= de_out_d;
        end
    end

    assign red    = red_q;
    assign green  = green_q;
    assign blue   = blue_q;
    assign de_out = de_out_q;
    assign step   = step_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen with FRAMES_PER_STEP=2 so frame steps are cheap.
// Frames are abbreviated: only the pixels of interest plus the frame-end pixel are driven.
module tb_video_pattern_gen;

    logic        pixel_clk = 1'b0;
    logic        rst;
    logic        active_video;
    logic [9:0]  h_pos;
    logic [8:0]  v_pos;
    logic [1:0]  mode;
    logic [7:0]  red, green, blue;
    logic        de_out;
    logic [2:0]  step;

    int n_cmp = 0;
    int n_bad = 0;

    video_pattern_gen #(.FRAMES_PER_STEP(2)) dut (
        .pixel_clk    (pixel_clk),
        .rst          (rst),
        .active_video (active_video),
        .h_pos        (h_pos),
        .v_pos        (v_pos),
        .mode         (mode),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .de_out       (de_out),
        .step         (step)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    // Present one pixel for a single clock, then idle; read the result two edges later
    task automatic show(input logic av, input int h, input int v,
                        output logic [23:0] rgb, output logic de);
        active_video = av;
        h_pos        = 10'(h);
        v_pos        = 9'(v);
        tick();
        active_video = 1'b0;
        tick();
        rgb = {red, green, blue};
        de  = de_out;
    endtask

    task automatic test_reset();
        rst = 1'b1; active_video = 1'b1; h_pos = 10'd0; v_pos = 9'd0; mode = 2'd0;
        tick();
        tick();
        n_cmp++;
        if ({red, green, blue, de_out, step} !== 28'd0) begin
            n_bad++;
            $display("FAIL reset_state: got rgb=%h de=%b step=%0d want all zero", {red, green, blue}, de_out, step);
        end
        rst = 1'b0;
        active_video = 1'b0;
        tick();
    endtask

    task automatic test_bars();
        int          hs[5] = '{0, 80, 320, 400, 639};
        logic [23:0] ex[5] = '{24'hFFFFFF, 24'hFFFF00, 24'hFF00FF, 24'hFF0000, 24'h000000};
        logic [23:0] rgb;
        logic        de;
        for (int i = 0; i < 5; i++) begin
            show(1'b1, hs[i], 10, rgb, de);
            n_cmp++;
            if ({rgb, de} !== {ex[i], 1'b1}) begin
                n_bad++;
                $display("FAIL bars_h%0d: got rgb=%h de=%b want rgb=%h de=1", hs[i], rgb, de, ex[i]);
            end
        end
    endtask

    task automatic test_mode_sync();
        logic [23:0] rgb;
        logic        de;
        mode = 2'd3;
        show(1'b1, 80, 10, rgb, de);
        n_cmp++;
        if (rgb !== 24'hFFFF00) begin n_bad++; $display("FAIL mode_midframe: got %h want ffff00", rgb); end
        mode = 2'd0;
        show(1'b1, 639, 479, rgb, de);
        n_cmp++;
        if (rgb !== 24'h000000) begin n_bad++; $display("FAIL mode_fe1: got %h want 000000", rgb); end
        show(1'b1, 0, 10, rgb, de);
        n_cmp++;
        if (rgb !== 24'hFFFFFF) begin n_bad++; $display("FAIL mode_glitch_ignored: got %h want ffffff", rgb); end
        mode = 2'd3;
        show(1'b1, 639, 479, rgb, de);
        n_cmp++;
        if (rgb !== 24'h000000) begin n_bad++; $display("FAIL mode_fe2_old: got %h want 000000", rgb); end
        show(1'b1, 0, 10, rgb, de);
        n_cmp++;
        if ({rgb, step} !== {24'hFFFF00, 3'd1}) begin
            n_bad++; $display("FAIL mode_solid_first: got rgb=%h step=%0d want ffff00 step=1", rgb, step);
        end
        show(1'b1, 400, 200, rgb, de);
        n_cmp++;
        if (rgb !== 24'hFFFF00) begin n_bad++; $display("FAIL mode_solid_other: got %h want ffff00", rgb); end
    endtask

    task automatic test_ramp();
        int          hs[3] = '{0, 320, 639};
        logic [23:0] ex[3] = '{24'h000000, 24'h7F7F7F, 24'hFFFFFF};
        logic [23:0] rgb;
        logic        de;
        mode = 2'd2;
        show(1'b1, 639, 479, rgb, de);
        n_cmp++;
        if (rgb !== 24'hFFFF00) begin n_bad++; $display("FAIL ramp_fe_old: got %h want ffff00", rgb); end
        for (int i = 0; i < 3; i++) begin
            show(1'b1, hs[i], 10, rgb, de);
            n_cmp++;
            if ({rgb, de} !== {ex[i], 1'b1}) begin
                n_bad++;
                $display("FAIL ramp_h%0d: got rgb=%h de=%b want rgb=%h de=1", hs[i], rgb, de, ex[i]);
            end
        end
        show(1'b0, 320, 10, rgb, de);
        n_cmp++;
        if ({rgb, de} !== 25'd0) begin n_bad++; $display("FAIL ramp_blank: got rgb=%h de=%b want 0 0", rgb, de); end
    endtask

    task automatic test_grid();
        logic [23:0] rgb;
        logic        de;
        mode = 2'd1;
        show(1'b1, 639, 479, rgb, de);
        n_cmp++;
        if (rgb !== 24'hFFFFFF) begin n_bad++; $display("FAIL grid_fe_ramp: got %h want ffffff", rgb); end
        show(1'b1, 0, 0, rgb, de);
        n_cmp++;
        if ({rgb, step} !== {24'h00FFFF, 3'd2}) begin
            n_bad++; $display("FAIL grid_step2: got rgb=%h step=%0d want 00ffff step=2", rgb, step);
        end
        show(1'b1, 639, 479, rgb, de);
        n_cmp++;
        if (rgb !== 24'hFFFFFF) begin n_bad++; $display("FAIL grid_fe_pixel: got %h want ffffff", rgb); end
        show(1'b1, 0, 0, rgb, de);
        n_cmp++;
        if ({rgb, step} !== {24'h00FFFF, 3'd2}) begin
            n_bad++; $display("FAIL grid_hold: got rgb=%h step=%0d want 00ffff step=2", rgb, step);
        end
        show(1'b1, 639, 479, rgb, de);
        show(1'b1, 0, 0, rgb, de);
        n_cmp++;
        if ({rgb, step} !== {24'h00FF00, 3'd3}) begin
            n_bad++; $display("FAIL grid_step3: got rgb=%h step=%0d want 00ff00 step=3", rgb, step);
        end
        show(1'b1, 80, 60, rgb, de);
        n_cmp++;
        if (rgb !== 24'hFF0000) begin n_bad++; $display("FAIL grid_cell11: got %h want ff0000", rgb); end
        for (int i = 0; i < 8; i++) show(1'b1, 639, 479, rgb, de);
        show(1'b1, 0, 0, rgb, de);
        n_cmp++;
        if ({rgb, step} !== {24'h000000, 3'd7}) begin
            n_bad++; $display("FAIL grid_step7: got rgb=%h step=%0d want 000000 step=7", rgb, step);
        end
        for (int i = 0; i < 2; i++) show(1'b1, 639, 479, rgb, de);
        show(1'b1, 0, 0, rgb, de);
        n_cmp++;
        if ({rgb, step} !== {24'hFFFFFF, 3'd0}) begin
            n_bad++; $display("FAIL grid_wrap: got rgb=%h step=%0d want ffffff step=0", rgb, step);
        end
    endtask

    task automatic test_mid_reset();
        logic [23:0] rgb;
        logic        de;
        for (int i = 0; i < 10; i++) show(1'b1, 639, 479, rgb, de);
        n_cmp++;
        if (step !== 3'd5) begin n_bad++; $display("FAIL rst_pre_step: got %0d want 5", step); end
        active_video = 1'b1; h_pos = 10'd0; v_pos = 9'd0;
        tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({red, green, blue, de_out, step} !== 28'd0) begin
            n_bad++;
            $display("FAIL rst_mid: got rgb=%h de=%b step=%0d want all zero", {red, green, blue}, de_out, step);
        end
        tick();
        tick();
        rst = 1'b0;
        active_video = 1'b1; h_pos = 10'd80; v_pos = 9'd10;
        tick();
        n_cmp++;
        if ({red, green, blue, de_out} !== 25'd0) begin
            n_bad++; $display("FAIL rst_latency: got rgb=%h de=%b want 0 0", {red, green, blue}, de_out);
        end
        active_video = 1'b0;
        tick();
        n_cmp++;
        if ({red, green, blue, de_out} !== {24'hFFFF00, 1'b1}) begin
            n_bad++; $display("FAIL rst_first_pixel: got rgb=%h de=%b want ffff00 1", {red, green, blue}, de_out);
        end
        tick();
        n_cmp++;
        if (de_out !== 1'b0) begin n_bad++; $display("FAIL rst_de_drop: got %b want 0", de_out); end
    endtask

    task automatic test_out_of_range();
        logic [23:0] rgb;
        logic        de;
        show(1'b1, 700, 10, rgb, de);
        n_cmp++;
        if ({rgb, de} !== {24'h000000, 1'b1}) begin
            n_bad++; $display("FAIL oor_h700: got rgb=%h de=%b want 000000 1", rgb, de);
        end
        show(1'b1, 10, 500, rgb, de);
        n_cmp++;
        if ({rgb, de} !== {24'h000000, 1'b1}) begin
            n_bad++; $display("FAIL oor_v500: got rgb=%h de=%b want 000000 1", rgb, de);
        end
    endtask

    initial begin
        test_reset();
        test_bars();
        test_mode_sync();
        test_ramp();
        test_grid();
        test_mid_reset();
        test_out_of_range();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
